soc_mem_loader: RTL and testbench

//  Hardware loader for the SoC's byte-laned RAMs (imem/dmem symbol arrays).

---
 rtl/soc_mem_loader.sv | 216 +++++++++++++++++++++
 tb/tb_soc_mem_loader.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_mem_loader.sv
// Framed byte-stream loader: CMD | ADDR(4 LE) | LEN(4 LE) | payload,
// packed into word writes with byte strobes on one of NUM_MEM RAMs.
// Ports:
//   i_clk, i_reset            clock, sync active-high reset
//   i_load_en                 enable; low aborts the frame and idles
//   i_in_valid/i_in_data      byte stream in; o_in_ready accepts
//   o_mem_wr_en[NUM_MEM]      one-hot write strobe per target RAM
//   o_mem_addr/wdata/wstrb    word address, data, byte-lane enables
//   o_busy, o_done, o_error   frame status; done/error are 1-cycle pulses
module soc_mem_loader #(
  parameter  int DATA_WIDTH = 32,
  parameter  int ADDR_WIDTH = 16,
  parameter  int NUM_MEM    = 2,
  localparam int BYTES      = DATA_WIDTH / 8,
  localparam int LB         = $clog2(BYTES),
  localparam int WA         = ADDR_WIDTH - LB
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_load_en,
  input  logic                  i_in_valid,
  input  logic [7:0]            i_in_data,
  output logic                  o_in_ready,
  output logic [NUM_MEM-1:0]    o_mem_wr_en,
  output logic [WA-1:0]         o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  output logic [BYTES-1:0]      o_mem_wstrb,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_LEN, S_DATA, S_DRAIN
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [1:0]            r_cnt;
  logic [6:0]            r_tgt;
  logic [ADDR_WIDTH-1:0] r_addr;
  // Shift register for both the ADDR and LEN fields, then
  // the remaining byte count during DATA/DRAIN.
  logic [31:0]           r_len;
  logic [DATA_WIDTH-1:0] r_pack;
  logic [BYTES-1:0]      r_strb;
  logic [NUM_MEM-1:0]    r_wr_en;
  logic [WA-1:0]         r_waddr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [BYTES-1:0]      r_wstrb;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_error;

  logic                  w_acc;
  logic                  w_start;
  logic [31:0]           w_len_nx;
  logic [LB-1:0]         w_lane;
  logic                  w_last;
  logic                  w_top;
  logic                  w_flush;
  logic                  w_fin_ok;
  logic                  w_fin_err;
  logic [DATA_WIDTH-1:0] w_pack;
  logic [BYTES-1:0]      w_strb;
  logic [NUM_MEM-1:0]    w_sel;

  assign o_in_ready  = (r_state != S_IDLE);
  assign o_mem_wr_en = r_wr_en;
  assign o_mem_addr  = r_waddr;
  assign o_mem_wdata = r_wdata;
  assign o_mem_wstrb = r_wstrb;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_error     = r_error;

  always_comb begin
    w_acc    = i_in_valid && o_in_ready;
    w_start  = (r_state == S_CMD) && w_acc && i_in_data[7];
    w_len_nx = {i_in_data, r_len[31:8]};
    w_lane   = r_addr[LB-1:0];
    w_last   = (r_len == 32'd1);
    w_top    = &r_addr;
    w_pack   = r_pack;
    w_pack[{w_lane, 3'b000} +: 8] = i_in_data;
    w_strb   = r_strb | (BYTES'(1) << w_lane);
    w_sel    = '0;
    for (int i = 0; i < NUM_MEM; i++)
      w_sel[i] = (r_tgt == 7'(i));
  end

  always_comb begin
    w_next    = r_state;
    w_flush   = 1'b0;
    w_fin_ok  = 1'b0;
    w_fin_err = 1'b0;
    unique case (r_state)
      S_IDLE:
        if (i_load_en) w_next = S_CMD;
      S_CMD:
        if (w_start) w_next = S_ADDR;
      S_ADDR:
        if (w_acc && r_cnt == 2'd3) w_next = S_LEN;
      S_LEN:
        if (w_acc && r_cnt == 2'd3) begin
          if (w_len_nx == 32'd0) begin
            w_next   = S_CMD;
            w_fin_ok = 1'b1;
          end else if (r_tgt >= 7'(NUM_MEM)) begin
            w_next = S_DRAIN;
          end else begin
            w_next = S_DATA;
          end
        end
      S_DATA:
        if (w_acc) begin
          // The top byte address always sits in the last lane,
          // so an overflow flushes through the lane test.
          w_flush = w_last || (w_lane == LB'(BYTES - 1));
          if (w_last) begin
            w_next   = S_CMD;
            w_fin_ok = 1'b1;
          end else if (w_top) begin
            w_next = S_DRAIN;
          end
        end
      S_DRAIN:
        if (w_acc && w_last) begin
          w_next    = S_CMD;
          w_fin_err = 1'b1;
        end
      default: w_next = S_IDLE;
    endcase
    // Abort wins over everything in flight, including a flush.
    if (r_state != S_IDLE && !i_load_en) begin
      w_next    = S_IDLE;
      w_flush   = 1'b0;
      w_fin_ok  = 1'b0;
      w_fin_err = r_busy;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_tgt   <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_pack  <= '0;
      r_strb  <= '0;
      r_wr_en <= '0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= w_fin_ok;
      r_error <= w_fin_err;
      r_wr_en <= '0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      if (w_fin_ok || w_fin_err || w_next == S_IDLE)
        r_busy <= 1'b0;
      else if (w_start)
        r_busy <= 1'b1;
      case (r_state)
        S_CMD:
          if (w_start) begin
            r_tgt <= i_in_data[6:0];
            r_cnt <= 2'd0;
          end
        S_ADDR:
          if (w_acc) begin
            r_len <= w_len_nx;
            r_cnt <= r_cnt + 2'd1;
            if (r_cnt == 2'd3)
              r_addr <= w_len_nx[ADDR_WIDTH-1:0];
          end
        S_LEN:
          if (w_acc) begin
            r_len <= w_len_nx;
            r_cnt <= r_cnt + 2'd1;
          end
        S_DATA:
          if (w_acc) begin
            r_addr <= r_addr + ADDR_WIDTH'(1);
            r_len  <= r_len - 32'd1;
            if (w_flush) begin
              r_wr_en <= w_sel;
              r_waddr <= r_addr[ADDR_WIDTH-1:LB];
              r_wdata <= w_pack;
              r_wstrb <= w_strb;
              r_pack  <= '0;
              r_strb  <= '0;
            end else begin
              r_pack <= w_pack;
              r_strb <= w_strb;
            end
          end
        S_DRAIN:
          if (w_acc) r_len <= r_len - 32'd1;
        default: ;
      endcase
      if (w_next == S_IDLE) begin
        r_pack <= '0;
        r_strb <= '0;
      end
    end
  end

endmodule

// File: tb/tb_soc_mem_loader.sv
// Scoreboard bench for soc_mem_loader: expected writes are queued
// as frames are driven and popped by a negedge monitor.
module tb_soc_mem_loader;

  logic        clk;
  logic        rst;
  logic        load_en;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [1:0]  wr_en;
  logic [13:0] maddr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        busy;
  logic        done;
  logic        error;

  typedef struct packed {
    logic [1:0]  en;
    logic [13:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } wr_t;

  wr_t exp_q[$];
  wr_t e;
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  n_done = 0;
  int  n_err = 0;
  int  last_wr = -1;
  int  last_done = -2;

  soc_mem_loader dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_load_en   (load_en),
    .i_in_valid  (in_valid),
    .i_in_data   (in_data),
    .o_in_ready  (in_ready),
    .o_mem_wr_en (wr_en),
    .o_mem_addr  (maddr),
    .o_mem_wdata (wdata),
    .o_mem_wstrb (wstrb),
    .o_busy      (busy),
    .o_done      (done),
    .o_error     (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      checks++;
      if (wr_en != 2'b00) begin
        last_wr = cyc;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write got en=%b a=%h d=%h s=%h",
                   wr_en, maddr, wdata, wstrb);
        end else begin
          e = exp_q.pop_front();
          if ({wr_en, maddr, wdata, wstrb} !== e) begin
            errors++;
            $display("FAIL write got en=%b a=%h d=%h s=%h exp en=%b a=%h d=%h s=%h",
                     wr_en, maddr, wdata, wstrb, e.en, e.a, e.d, e.s);
          end
        end
      end else if ({maddr, wdata, wstrb} !== 50'd0) begin
        errors++;
        $display("FAIL idle_bus got a=%h d=%h s=%h exp 0",
                 maddr, wdata, wstrb);
      end
      if (done) begin
        n_done++;
        last_done = cyc;
      end
      if (error) n_err++;
      if (done || error) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL busy_at_pulse got %b exp 0", busy);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int maxgap);
    int  n;
    int  gap;
    logic ok;
    gap = (maxgap > 0) ? $urandom_range(0, maxgap) : 0;
    repeat (gap) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    do begin
      ok = in_ready;
      @(posedge clk); #1;
      n++;
    end while (!ok && n < 20);
    in_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout byte=%h got no ready exp ready", b);
    end
  endtask

  task automatic send_hdr(input logic [7:0] cmd, input logic [31:0] a,
                          input logic [31:0] len, input int g);
    send_byte(cmd, g);
    for (int i = 0; i < 4; i++) send_byte(a[i*8 +: 8], g);
    for (int i = 0; i < 4; i++) send_byte(len[i*8 +: 8], g);
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h80;
    load_en  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, wr_en, busy, done, error} !== 6'd0) begin
      errors++;
      $display("FAIL reset_outs got %b exp 000000",
               {in_ready, wr_en, busy, done, error});
    end
    checks++;
    if ({maddr, wdata, wstrb} !== 50'd0) begin
      errors++;
      $display("FAIL reset_bus got %h exp 0", {maddr, wdata, wstrb});
    end
    in_valid = 1'b0;
    load_en  = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_ready got %b exp 0", in_ready);
    end
    load_en = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL cmd_ready got %b exp 1", in_ready);
    end
  endtask

  task automatic run_case1(input string nm, input int g);
    int d0;
    int e0;
    logic [7:0] b;
    d0 = n_done;
    e0 = n_err;
    exp_q.push_back({2'b01, 14'h0000, 32'h44332211, 4'hF});
    exp_q.push_back({2'b01, 14'h0001, 32'h88776655, 4'hF});
    send_byte(8'h80, g);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy got %b exp 1", nm, busy);
    end
    for (int i = 0; i < 4; i++) send_byte(8'h00, g);
    send_byte(8'h08, g);
    for (int i = 0; i < 3; i++) send_byte(8'h00, g);
    for (int i = 1; i <= 8; i++) begin
      b = 8'(i * 8'h11);
      send_byte(b, g);
    end
    settle();
    checks++;
    if (n_done !== d0 + 1 || n_err !== e0) begin
      errors++;
      $display("FAIL %s pulses got done=%0d err=%0d exp done=%0d err=%0d",
               nm, n_done - d0, n_err - e0, 1, 0);
    end
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL %s missing_writes got %0d left exp 0", nm, exp_q.size());
    end
    checks++;
    if (last_done !== last_wr) begin
      errors++;
      $display("FAIL %s done_align got done@%0d exp write@%0d",
               nm, last_done, last_wr);
    end
  endtask

  task automatic test_aligned();
    run_case1("aligned", 0);
  endtask

  task automatic test_unaligned();
    int d0;
    d0 = n_done;
    exp_q.push_back({2'b10, 14'h0001, 32'hBBAA0000, 4'hC});
    exp_q.push_back({2'b10, 14'h0002, 32'h000000CC, 4'h1});
    send_hdr(8'h81, 32'h6, 32'h3, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    send_byte(8'hCC, 0);
    settle();
    checks++;
    if (n_done !== d0 + 1 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL unaligned got done=%0d left=%0d exp done=1 left=0",
               n_done - d0, exp_q.size());
    end
  endtask

  task automatic test_bad_target();
    int e0;
    int d0;
    e0 = n_err;
    d0 = n_done;
    send_hdr(8'h85, 32'h0, 32'h4, 0);
    for (int i = 0; i < 3; i++) send_byte(8'h5A, 0);
    settle();
    checks++;
    if (n_err !== e0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL bad_tgt_early got err=%0d busy=%b exp err=0 busy=1",
               n_err - e0, busy);
    end
    send_byte(8'h5A, 0);
    settle();
    checks++;
    if (n_err !== e0 + 1 || n_done !== d0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bad_tgt got err=%0d done=%0d busy=%b exp 1 0 0",
               n_err - e0, n_done - d0, busy);
    end
  endtask

  task automatic test_overflow();
    int e0;
    int d0;
    e0 = n_err;
    d0 = n_done;
    exp_q.push_back({2'b01, 14'h3FFF, 32'h02010000, 4'hC});
    send_hdr(8'h80, 32'h0000FFFE, 32'h4, 0);
    for (int i = 1; i <= 4; i++) send_byte(8'(i), 0);
    settle();
    checks++;
    if (n_err !== e0 + 1 || n_done !== d0 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL overflow got err=%0d done=%0d left=%0d exp 1 0 0",
               n_err - e0, n_done - d0, exp_q.size());
    end
  endtask

  task automatic test_stalls();
    run_case1("stalls", 3);
  endtask

  task automatic test_abort();
    int e0;
    e0 = n_err;
    send_hdr(8'h80, 32'h10, 32'h8, 0);
    for (int i = 0; i < 3; i++) send_byte(8'hE0, 0);
    load_en = 1'b0;
    settle();
    checks++;
    if (n_err !== e0 + 1 || in_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort got err=%0d rdy=%b busy=%b exp 1 0 0",
               n_err - e0, in_ready, busy);
    end
    load_en = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_zero_len_junk();
    int d0;
    int e0;
    d0 = n_done;
    e0 = n_err;
    send_byte(8'h12, 0);
    send_byte(8'h12, 0);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL junk_busy got %b exp 0", busy);
    end
    send_hdr(8'h80, 32'h20, 32'h0, 0);
    send_byte(8'h12, 0);
    settle();
    checks++;
    if (n_done !== d0 + 1 || n_err !== e0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_len got done=%0d err=%0d busy=%b exp 1 0 0",
               n_done - d0, n_err - e0, busy);
    end
  endtask

  task automatic test_back_to_back();
    int d0;
    d0 = n_done;
    exp_q.push_back({2'b10, 14'h0000, 32'h0000005A, 4'h1});
    exp_q.push_back({2'b01, 14'h0000, 32'hE1000000, 4'h8});
    exp_q.push_back({2'b01, 14'h0001, 32'h000000E2, 4'h1});
    send_hdr(8'h81, 32'h0, 32'h1, 0);
    send_byte(8'h5A, 0);
    send_hdr(8'h80, 32'h3, 32'h2, 0);
    send_byte(8'hE1, 0);
    send_byte(8'hE2, 0);
    settle();
    checks++;
    if (n_done !== d0 + 2 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL back_to_back got done=%0d left=%0d exp 2 0",
               n_done - d0, exp_q.size());
    end
  endtask

  initial begin
    rst      = 1'b1;
    load_en  = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    test_reset();
    test_aligned();
    test_unaligned();
    test_bad_target();
    test_overflow();
    test_stalls();
    test_abort();
    test_zero_len_junk();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
